// File: rtl/vector_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : vector_decoder
//  Purpose  : Rebuilds 16 x int8 operands from radix-4 signed-digit lane codes
//             behind a 2-stage valid/ready pipeline with per-lane error flags.
//             Optional saturating error counter: VECTOR_DECODER_ERR_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module vector_decoder #(
    parameter int LANES = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           bit_enable             [0:LANES-1],
    input  logic [7:0]           partial_product_select [0:LANES-1],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   operand_a,
    output logic [LANES-1:0]     lane_err,
    output logic [CNT_W-1:0]     err_count
);

    logic                 r_v1;
    logic                 r_v2;
    logic [3:0]           r_en1  [0:LANES-1];
    logic [7:0]           r_sel1 [0:LANES-1];
    logic [8*LANES-1:0]   r_operand;
    logic [LANES-1:0]     r_lane_err;
    logic [8*LANES-1:0]   w_lane_val;
    logic [LANES-1:0]     w_lane_err;
    logic                 w_ready1;
    logic                 w_ready2;

    assign w_ready2  = ~r_v2 | out_ready;
    assign w_ready1  = ~r_v1 | w_ready2;
    assign in_ready  = w_ready1 & ~rst;
    assign out_valid = r_v2;
    assign operand_a = r_operand;
    assign lane_err  = r_lane_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_en1[k]  <= '0;
                r_sel1[k] <= '0;
            end
        end else begin
            if (w_ready1) begin
                r_v1 <= in_valid;
            end
            if (in_valid && w_ready1) begin
                for (int k = 0; k < LANES; k++) begin
                    r_en1[k]  <= bit_enable[k];
                    r_sel1[k] <= partial_product_select[k];
                end
            end
        end
    end

    // Decode is done from the S1 registers so S2 only captures finished bytes.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [8:0] w_dig [4];
        logic signed [8:0] w_sum;
        logic [3:0]        w_code_nz;
        logic [7:0]        w_val;
        logic              w_err;

        always_comb begin
            for (int d = 0; d < 4; d++) begin
                w_dig[d]     = '0;
                w_code_nz[d] = |r_sel1[k][2*d +: 2];
                if (r_en1[k][d]) begin
                    case (r_sel1[k][2*d +: 2])
                        2'b00:   w_dig[d] = -9'sd2;
                        2'b01:   w_dig[d] =  9'sd1;
                        2'b10:   w_dig[d] =  9'sd2;
                        default: w_dig[d] = -9'sd1;
                    endcase
                end
            end
            w_sum = w_dig[0] + (w_dig[1] <<< 2) + (w_dig[2] <<< 4) + (w_dig[3] <<< 6);
            w_err = |(w_code_nz & ~r_en1[k]);
            w_val = w_sum[7:0];
            if (w_sum > 9'sd127) begin
                w_val = 8'h7F;
                w_err = 1'b1;
            end else if (w_sum < -9'sd128) begin
                w_val = 8'h80;
                w_err = 1'b1;
            end
        end

        assign w_lane_val[8*k +: 8] = w_val;
        assign w_lane_err[k]        = w_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2       <= 1'b0;
            r_operand  <= '0;
            r_lane_err <= '0;
        end else if (w_ready2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_operand  <= w_lane_val;
                r_lane_err <= w_lane_err;
            end
        end
    end

`ifdef VECTOR_DECODER_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (r_v2 && out_ready && (|r_lane_err) && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vector_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_decoder
//  Purpose  : Directed table-driven bench for vector_decoder, plus streaming
//             backpressure and mid-flight reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vector_decoder;

    typedef struct packed {
        logic [15:0][3:0] en;
        logic [15:0][7:0] sel;
        logic [127:0]     op;
        logic [15:0]      err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   bit_enable             [0:15];
    logic [7:0]   partial_product_select [0:15];
    logic         out_valid;
    logic         out_ready;
    logic [127:0] operand_a;
    logic [15:0]  lane_err;
    logic [15:0]  err_count;

    int           checks = 0;
    int           errors = 0;
    logic [15:0]  exp_cnt = '0;

    vec_t vecs [5];
    vec_t strm [8];

    vector_decoder #(.LANES(16), .CNT_W(16)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .bit_enable             (bit_enable),
        .partial_product_select (partial_product_select),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .operand_a              (operand_a),
        .lane_err               (lane_err),
        .err_count              (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t with_lane(input vec_t v, input int k, input logic [3:0] en,
                                       input logic [7:0] sel, input logic [7:0] val, input logic e);
        vec_t r = v;
        r.en[k]        = en;
        r.sel[k]       = sel;
        r.op[8*k +: 8] = val;
        r.err[k]       = e;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        for (int k = 0; k < 16; k++) begin
            bit_enable[k]             = v.en[k];
            partial_product_select[k] = v.sel[k];
        end
    endtask

    task automatic drive_junk();
        for (int k = 0; k < 16; k++) begin
            bit_enable[k]             = 4'hF;
            partial_product_select[k] = 8'hAA;
        end
    endtask

    task automatic note_transfer(input logic [15:0] e);
`ifdef VECTOR_DECODER_ERR_CNT_EN
        if (e != 16'h0 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`else
        if (e != 16'h0) exp_cnt = exp_cnt;
`endif
    endtask

    // Single beat with out_ready high: checks 2-cycle latency and data.
    task automatic run_vec(input string name, input vec_t v);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(v);
        #1;
        chk({name, "_in_ready"}, {127'b0, in_ready}, 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        drive_junk();
        chk({name, "_lat1_out_valid"}, {127'b0, out_valid}, 128'd0);
        @(negedge clk);
        chk({name, "_out_valid"}, {127'b0, out_valid}, 128'd1);
        chk({name, "_operand"}, operand_a, v.op);
        chk({name, "_lane_err"}, {112'b0, lane_err}, {112'b0, v.err});
        note_transfer(v.err);
        @(negedge clk);
        chk({name, "_drained"}, {127'b0, out_valid}, 128'd0);
        chk({name, "_err_count"}, {112'b0, err_count}, {112'b0, exp_cnt});
    endtask

    initial begin
        logic [3:0] s_en  [8];
        logic [7:0] s_sel [8];
        logic [7:0] s_val [8];
        logic [7:0] pat;
        vec_t       z;
        int         sent, recv;
        logic       have_hold, saw_stall;
        logic [127:0] hold_op;
        logic [15:0]  hold_err;

        z = '0;
        vecs[0] = with_lane(z, 0, 4'b1001, 8'b10000011, 8'h7F, 1'b0);
        vecs[1] = with_lane(z, 5, 4'b1000, 8'b00000000, 8'h80, 1'b0);
        vecs[1] = with_lane(vecs[1], 6, 4'b0001, 8'b00000011, 8'hFF, 1'b0);
        vecs[1] = with_lane(vecs[1], 7, 4'b0011, 8'b00000101, 8'h05, 1'b0);
        vecs[2] = with_lane(z, 3, 4'b1111, 8'b10101010, 8'h7F, 1'b1);
        vecs[3] = with_lane(z, 9, 4'b0000, 8'b00000001, 8'h00, 1'b1);
        vecs[3] = with_lane(vecs[3], 10, 4'b1111, 8'b00000000, 8'h80, 1'b1);
        vecs[4] = vecs[1];
        vecs[4] = with_lane(vecs[4], 0,  4'b1001, 8'b10000011, 8'h7F, 1'b0);
        vecs[4] = with_lane(vecs[4], 1,  4'b0110, 8'b00111000, 8'hF8, 1'b0);
        vecs[4] = with_lane(vecs[4], 2,  4'b1111, 8'b01010101, 8'h55, 1'b0);
        vecs[4] = with_lane(vecs[4], 3,  4'b1111, 8'b10101010, 8'h7F, 1'b1);
        vecs[4] = with_lane(vecs[4], 4,  4'b1111, 8'b11111111, 8'hAB, 1'b0);
        vecs[4] = with_lane(vecs[4], 9,  4'b0000, 8'b00000001, 8'h00, 1'b1);
        vecs[4] = with_lane(vecs[4], 10, 4'b1111, 8'b00000000, 8'h80, 1'b1);
        vecs[4] = with_lane(vecs[4], 11, 4'b1000, 8'b10000000, 8'h7F, 1'b1);
        vecs[4] = with_lane(vecs[4], 12, 4'b1001, 8'b00000001, 8'h81, 1'b0);
        vecs[4] = with_lane(vecs[4], 13, 4'b1001, 8'b00000000, 8'h80, 1'b1);
        vecs[4] = with_lane(vecs[4], 14, 4'b0100, 8'b00010000, 8'h10, 1'b0);
        vecs[4] = with_lane(vecs[4], 15, 4'b0100, 8'b00100000, 8'h20, 1'b0);

        // Lane 15 tags each streamed beat with a distinct value.
        s_en  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        s_sel = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h08, 8'h0C, 8'h00};
        s_val = '{8'h01, 8'h02, 8'hFF, 8'hFE, 8'h04, 8'h08, 8'hFC, 8'hF8};
        for (int j = 0; j < 8; j++)
            strm[j] = with_lane(vecs[j % 5], 15, s_en[j], s_sel[j], s_val[j], 1'b0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(z);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_operand", operand_a, 128'd0);
        chk("rst_lane_err", {112'b0, lane_err}, 128'd0);
        chk("rst_err_count", {112'b0, err_count}, 128'd0);
        chk("rst_in_ready_after", {127'b0, in_ready}, 128'd1);

        for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Streaming with backpressure pattern 1,0,0,1,1,0,1,1.
        pat = 8'b11011001;
        sent = 0; recv = 0; have_hold = 1'b0; saw_stall = 1'b0;
        hold_op = '0; hold_err = '0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge clk);
            if (have_hold) begin
                chk("hold_valid", {127'b0, out_valid}, 128'd1);
                chk("hold_operand", operand_a, hold_op);
                chk("hold_lane_err", {112'b0, lane_err}, {112'b0, hold_err});
                have_hold = 1'b0;
            end
            out_ready = (cyc < 8) ? pat[cyc] : 1'b1;
            in_valid  = (sent < 8);
            if (sent < 8) drive(strm[sent]); else drive_junk();
            #1;
            if (!in_ready) saw_stall = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk($sformatf("strm%0d_operand", recv), operand_a, strm[recv].op);
                chk($sformatf("strm%0d_lane_err", recv), {112'b0, lane_err}, {112'b0, strm[recv].err});
                note_transfer(strm[recv].err);
                recv++;
            end else if (out_valid) begin
                have_hold = 1'b1;
                hold_op   = operand_a;
                hold_err  = lane_err;
            end
        end
        chk("strm_all_received", recv, 8);
        chk("strm_in_ready_fell", {127'b0, saw_stall}, 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("strm_err_count", {112'b0, err_count}, {112'b0, exp_cnt});

        // Two beats in flight, then a one-cycle reset.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(vecs[2]);
        @(negedge clk);
        drive(vecs[3]);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        exp_cnt = '0;
        chk("mrst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("mrst_operand", operand_a, 128'd0);
        chk("mrst_lane_err", {112'b0, lane_err}, 128'd0);
        chk("mrst_err_count", {112'b0, err_count}, 128'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mrst_dropped", {127'b0, out_valid}, 128'd0);
        end
        run_vec("post_rst", vecs[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
